// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg: shared states, encodings and decode helpers for the multicycle controller.
package mc_controller_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECUTER, S_EXECUTEI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2, S_LUI, S_AUIPC
  } state_t;
  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100, ALU_SLT = 4'b0101, ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b1000, ALU_SRL = 4'b1001, ALU_SRA = 4'b1010;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10, SRCA_ZERO = 2'b11;
  localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_MEM = 2'b01, RES_ALURESULT = 2'b10;
  function automatic logic [2:0] imm_src(input logic [6:0] op);
    return (op == OP_STORE) ? IMM_S :
           (op == OP_BRANCH) ? IMM_B :
           (op == OP_JAL) ? IMM_J :
           (op == OP_LUI || op == OP_AUIPC) ? IMM_U : IMM_I;
  endfunction
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero, input logic lt, input logic ltu);
    return (f3 == 3'b000) ? zero :
           (f3 == 3'b001) ? ~zero :
           (f3 == 3'b100) ? lt :
           (f3 == 3'b101) ? ~lt :
           (f3 == 3'b110) ? ltu :
           (f3 == 3'b111) ? ~ltu : 1'b0;
  endfunction
endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if: IR fields, ALU flags, memory handshake and datapath controls.
interface mc_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero, lt, ltu;
  logic       MemReady;
  logic [3:0] ALUControl;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ImmSrc;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
  logic       Illegal;
  modport slave (
    input  op, funct3, funct7b5, Zero, lt, ltu, MemReady,
    output ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, Illegal
  );
  modport master (
    output op, funct3, funct7b5, Zero, lt, ltu, MemReady,
    input  ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, Illegal
  );
endinterface

// File: rtl/alu_decoder.sv
// alu_decoder: maps funct3/funct7b5 to ALUControl; immediate ops never subtract.
module alu_decoder
  import mc_controller_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_itype,
  output logic [3:0] o_alu_control
);
  always_comb begin
    o_alu_control = ALU_AND;
    case (i_funct3)
      3'b000: o_alu_control = (i_funct7b5 && !i_itype) ? ALU_SUB : ALU_ADD;
      3'b001: o_alu_control = ALU_SLL;
      3'b010: o_alu_control = ALU_SLT;
      3'b011: o_alu_control = ALU_SLTU;
      3'b100: o_alu_control = ALU_XOR;
      3'b101: o_alu_control = i_funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: o_alu_control = ALU_OR;
      default: o_alu_control = ALU_AND;
    endcase
  end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle RV32I control FSM driving datapath muxes and write enables.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mc_controller_if.slave bus
);
  state_t     r_state, w_next;
  logic [3:0] w_alu_dec, w_alu_ctl;
  logic [1:0] w_srca, w_srcb, w_res;
  logic       w_pcw, w_irw, w_rw, w_mw, w_adr, w_ill;
  alu_decoder u_alu_dec (
    .i_funct3     (bus.funct3),
    .i_funct7b5   (bus.funct7b5),
    .i_itype      (r_state == S_EXECUTEI),
    .o_alu_control(w_alu_dec)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  always_comb begin
    w_next    = S_FETCH;
    w_alu_ctl = ALU_ADD;
    w_srca    = SRCA_PC;
    w_srcb    = SRCB_RS2;
    w_res     = RES_ALUOUT;
    w_pcw     = 1'b0;
    w_irw     = 1'b0;
    w_rw      = 1'b0;
    w_mw      = 1'b0;
    w_adr     = 1'b0;
    w_ill     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_srcb = SRCB_FOUR;
        w_res  = RES_ALURESULT;
        w_irw  = bus.MemReady;
        w_pcw  = bus.MemReady;
        w_next = bus.MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_srca = SRCA_OLDPC;
        w_srcb = SRCB_IMM;
        case (bus.op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECUTER;
          OP_ITYPE:          w_next = S_EXECUTEI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR1;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_AUIPC;
          default:           w_ill  = 1'b1;
        endcase
      end
      S_MEMADR: begin
        w_srca = SRCA_RS1;
        w_srcb = SRCB_IMM;
        w_next = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_adr  = 1'b1;
        w_next = bus.MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_res = RES_MEM;
        w_rw  = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr  = 1'b1;
        w_mw   = 1'b1;
        w_next = bus.MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER, S_EXECUTEI: begin
        w_srca    = SRCA_RS1;
        w_srcb    = (r_state == S_EXECUTEI) ? SRCB_IMM : SRCB_RS2;
        w_alu_ctl = w_alu_dec;
        w_next    = S_ALUWB;
      end
      S_ALUWB: w_rw = 1'b1;
      S_BRANCH: begin
        w_srca    = SRCA_RS1;
        w_alu_ctl = ALU_SUB;
        w_pcw     = branch_taken(bus.funct3, bus.Zero, bus.lt, bus.ltu);
      end
      S_JAL, S_JALR2: begin
        w_srca = SRCA_OLDPC;
        w_srcb = SRCB_FOUR;
        w_pcw  = 1'b1;
        w_next = S_ALUWB;
      end
      S_JALR1: begin
        w_srca = SRCA_RS1;
        w_srcb = SRCB_IMM;
        w_next = S_JALR2;
      end
      S_LUI, S_AUIPC: begin
        w_srca = (r_state == S_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        w_srcb = SRCB_IMM;
        w_next = S_ALUWB;
      end
      default: w_next = S_FETCH;
    endcase
  end
  // Enables are gated by reset so FETCH cannot fire IRWrite/PCWrite while held in reset.
  assign bus.PCWrite    = w_pcw & ~reset;
  assign bus.IRWrite    = w_irw & ~reset;
  assign bus.RegWrite   = w_rw & ~reset;
  assign bus.MemWrite   = w_mw & ~reset;
  assign bus.Illegal    = w_ill & ~reset;
  assign bus.AdrSrc     = w_adr;
  assign bus.ALUControl = w_alu_ctl;
  assign bus.ALUSrcA    = w_srca;
  assign bus.ALUSrcB    = w_srcb;
  assign bus.ResultSrc  = w_res;
  assign bus.ImmSrc     = imm_src(bus.op);
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed scenario tests for the multicycle controller.
module tb_mc_controller;
  import mc_controller_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  mc_controller_if bus();
  mc_controller dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  wire [4:0] en  = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.Illegal};
  wire [6:0] mux = {bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc};
  wire [3:0] st  = dut.r_state;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    @(negedge clk);
    reset = 1'b1;
    bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7;
    bus.Zero = 1'b0; bus.lt = 1'b0; bus.ltu = 1'b0; bus.MemReady = 1'b1;
    #2 reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.op = OP_RTYPE; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
    bus.Zero = 1'b0; bus.lt = 1'b0; bus.ltu = 1'b0; bus.MemReady = 1'b1;
    #3;
    n_chk++; if (en !== 5'b00000) begin n_fail++; $display("FAIL reset_en got %b exp %b", en, 5'b00000); end
    n_chk++; if (st !== 4'(S_FETCH)) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", st, S_FETCH); end
    n_chk++; if (bus.ALUControl !== 4'b0000) begin n_fail++; $display("FAIL reset_aluctl got %b exp 0000", bus.ALUControl); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_chk++; if (en !== 5'b11000) begin n_fail++; $display("FAIL reset_release_en got %b exp %b", en, 5'b11000); end
    n_chk++; if (mux !== 7'b0001010) begin n_fail++; $display("FAIL fetch_mux got %b exp %b", mux, 7'b0001010); end
  endtask

  task automatic test_add();
    start(OP_RTYPE, 3'b000, 1'b0);
    n_chk++; if (st !== 4'(S_FETCH) || en !== 5'b11000) begin n_fail++; $display("FAIL add_fetch got st %0d en %b exp st %0d en 11000", st, en, S_FETCH); end
    step();
    n_chk++; if (st !== 4'(S_DECODE) || en !== 5'b00000) begin n_fail++; $display("FAIL add_decode got st %0d en %b exp st %0d en 00000", st, en, S_DECODE); end
    n_chk++; if (mux[5:2] !== 4'b0101) begin n_fail++; $display("FAIL add_decode_src got %b exp 0101", mux[5:2]); end
    step();
    n_chk++; if (st !== 4'(S_EXECUTER) || en !== 5'b00000) begin n_fail++; $display("FAIL add_exec got st %0d en %b exp st %0d en 00000", st, en, S_EXECUTER); end
    n_chk++; if (bus.ALUControl !== 4'b0000) begin n_fail++; $display("FAIL add_aluctl got %b exp 0000", bus.ALUControl); end
    n_chk++; if (mux !== 7'b0100000) begin n_fail++; $display("FAIL add_exec_mux got %b exp %b", mux, 7'b0100000); end
    step();
    n_chk++; if (st !== 4'(S_ALUWB) || en !== 5'b00100) begin n_fail++; $display("FAIL add_aluwb got st %0d en %b exp st %0d en 00100", st, en, S_ALUWB); end
    n_chk++; if (bus.ResultSrc !== 2'b00) begin n_fail++; $display("FAIL add_aluwb_res got %b exp 00", bus.ResultSrc); end
    step();
    n_chk++; if (st !== 4'(S_FETCH)) begin n_fail++; $display("FAIL add_back_fetch got %0d exp %0d", st, S_FETCH); end
  endtask

  task automatic test_alu_decode();
    start(OP_RTYPE, 3'b101, 1'b1);
    step(); step();
    n_chk++; if (bus.ALUControl !== 4'b1010) begin n_fail++; $display("FAIL sra_aluctl got %b exp 1010", bus.ALUControl); end
    start(OP_ITYPE, 3'b101, 1'b1);
    step(); step();
    n_chk++; if (st !== 4'(S_EXECUTEI)) begin n_fail++; $display("FAIL srai_state got %0d exp %0d", st, S_EXECUTEI); end
    n_chk++; if (bus.ALUControl !== 4'b1010) begin n_fail++; $display("FAIL srai_aluctl got %b exp 1010", bus.ALUControl); end
    n_chk++; if (bus.ALUSrcB !== 2'b01) begin n_fail++; $display("FAIL srai_srcb got %b exp 01", bus.ALUSrcB); end
    start(OP_ITYPE, 3'b000, 1'b1);
    step(); step();
    n_chk++; if (bus.ALUControl !== 4'b0000) begin n_fail++; $display("FAIL addi_f7_aluctl got %b exp 0000", bus.ALUControl); end
    start(OP_RTYPE, 3'b000, 1'b1);
    step(); step();
    n_chk++; if (bus.ALUControl !== 4'b0001) begin n_fail++; $display("FAIL sub_aluctl got %b exp 0001", bus.ALUControl); end
    start(OP_RTYPE, 3'b011, 1'b0);
    step(); step();
    n_chk++; if (bus.ALUControl !== 4'b0110) begin n_fail++; $display("FAIL sltu_aluctl got %b exp 0110", bus.ALUControl); end
  endtask

  task automatic test_branch();
    start(OP_BRANCH, 3'b001, 1'b0);
    n_chk++; if (bus.ImmSrc !== 3'b010) begin n_fail++; $display("FAIL bne_immsrc got %b exp 010", bus.ImmSrc); end
    step(); step();
    n_chk++; if (st !== 4'(S_BRANCH) || en !== 5'b10000) begin n_fail++; $display("FAIL bne_taken got st %0d en %b exp st %0d en 10000", st, en, S_BRANCH); end
    n_chk++; if (bus.ALUControl !== 4'b0001) begin n_fail++; $display("FAIL branch_aluctl got %b exp 0001", bus.ALUControl); end
    bus.Zero = 1'b1;
    #1;
    n_chk++; if (en !== 5'b00000) begin n_fail++; $display("FAIL bne_not_taken got %b exp 00000", en); end
    step();
    n_chk++; if (st !== 4'(S_FETCH)) begin n_fail++; $display("FAIL branch_next got %0d exp %0d", st, S_FETCH); end
    start(OP_BRANCH, 3'b111, 1'b0);
    bus.ltu = 1'b1;
    step(); step();
    n_chk++; if (en !== 5'b00000) begin n_fail++; $display("FAIL bgeu_ltu got %b exp 00000", en); end
    bus.ltu = 1'b0;
    #1;
    n_chk++; if (en !== 5'b10000) begin n_fail++; $display("FAIL bgeu_taken got %b exp 10000", en); end
    bus.funct3 = 3'b010; bus.Zero = 1'b1; bus.lt = 1'b1;
    #1;
    n_chk++; if (en !== 5'b00000) begin n_fail++; $display("FAIL branch_f3_010 got %b exp 00000", en); end
  endtask

  task automatic test_load_stall();
    start(OP_LOAD, 3'b010, 1'b0);
    step(); step();
    n_chk++; if (st !== 4'(S_MEMADR) || mux !== 7'b0100100) begin n_fail++; $display("FAIL lw_memadr got st %0d mux %b exp st %0d mux 0100100", st, mux, S_MEMADR); end
    step();
    bus.MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (st !== 4'(S_MEMREAD) || en !== 5'b00000 || bus.AdrSrc !== 1'b1) begin n_fail++; $display("FAIL lw_stall%0d got st %0d en %b adr %b exp st %0d en 00000 adr 1", i, st, en, bus.AdrSrc, S_MEMREAD); end
    end
    bus.MemReady = 1'b1;
    step();
    n_chk++; if (st !== 4'(S_MEMWB) || en !== 5'b00100 || bus.ResultSrc !== 2'b01) begin n_fail++; $display("FAIL lw_memwb got st %0d en %b res %b exp st %0d en 00100 res 01", st, en, bus.ResultSrc, S_MEMWB); end
    step();
    n_chk++; if (st !== 4'(S_FETCH)) begin n_fail++; $display("FAIL lw_back_fetch got %0d exp %0d", st, S_FETCH); end
  endtask

  task automatic test_illegal();
    start(7'b1111111, 3'b000, 1'b0);
    step();
    n_chk++; if (st !== 4'(S_DECODE) || en !== 5'b00001) begin n_fail++; $display("FAIL illegal_decode got st %0d en %b exp st %0d en 00001", st, en, S_DECODE); end
    bus.MemReady = 1'b0;
    step();
    n_chk++; if (st !== 4'(S_FETCH) || en !== 5'b00000) begin n_fail++; $display("FAIL illegal_next got st %0d en %b exp st %0d en 00000", st, en, S_FETCH); end
  endtask

  task automatic test_jal();
    start(OP_JAL, 3'b000, 1'b0);
    n_chk++; if (bus.ImmSrc !== 3'b011) begin n_fail++; $display("FAIL jal_immsrc got %b exp 011", bus.ImmSrc); end
    step(); step();
    n_chk++; if (st !== 4'(S_JAL) || en !== 5'b10000 || mux !== 7'b0011000) begin n_fail++; $display("FAIL jal_state got st %0d en %b mux %b exp st %0d en 10000 mux 0011000", st, en, mux, S_JAL); end
    step();
    n_chk++; if (st !== 4'(S_ALUWB)) begin n_fail++; $display("FAIL jal_next got %0d exp %0d", st, S_ALUWB); end
    start(OP_LUI, 3'b000, 1'b0);
    step(); step();
    n_chk++; if (st !== 4'(S_LUI) || mux[5:2] !== 4'b1101) begin n_fail++; $display("FAIL lui got st %0d src %b exp st %0d src 1101", st, mux[5:2], S_LUI); end
  endtask

  task automatic test_reset_memwrite();
    start(OP_STORE, 3'b010, 1'b0);
    step(); step();
    bus.MemReady = 1'b0;
    step();
    n_chk++; if (st !== 4'(S_MEMWRITE) || en !== 5'b00010 || bus.AdrSrc !== 1'b1) begin n_fail++; $display("FAIL sw_memwrite got st %0d en %b adr %b exp st %0d en 00010 adr 1", st, en, bus.AdrSrc, S_MEMWRITE); end
    step();
    n_chk++; if (st !== 4'(S_MEMWRITE) || en !== 5'b00010) begin n_fail++; $display("FAIL sw_stall got st %0d en %b exp st %0d en 00010", st, en, S_MEMWRITE); end
    #1 reset = 1'b1;
    #1;
    n_chk++; if (st !== 4'(S_FETCH) || en !== 5'b00000) begin n_fail++; $display("FAIL sw_abort got st %0d en %b exp st %0d en 00000", st, en, S_FETCH); end
    bus.MemReady = 1'b1;
    #1;
    n_chk++; if (en !== 5'b00000) begin n_fail++; $display("FAIL reset_memready got %b exp 00000", en); end
    bus.MemReady = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_chk++; if (st !== 4'(S_FETCH) || en !== 5'b00000) begin n_fail++; $display("FAIL post_reset_gate got st %0d en %b exp st %0d en 00000", st, en, S_FETCH); end
    step();
    n_chk++; if (st !== 4'(S_FETCH)) begin n_fail++; $display("FAIL post_reset_hold got %0d exp %0d", st, S_FETCH); end
    bus.MemReady = 1'b1;
    #1;
    n_chk++; if (en !== 5'b11000) begin n_fail++; $display("FAIL post_reset_fetch got %b exp 11000", en); end
    step();
    n_chk++; if (st !== 4'(S_DECODE)) begin n_fail++; $display("FAIL post_reset_decode got %0d exp %0d", st, S_DECODE); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_decode();
    test_branch();
    test_load_stall();
    test_illegal();
    test_jal();
    test_reset_memwrite();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports SHALL be as listed below, clock and reset first.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 op  in  7  opcode field of the instruction register (IR).
REQ-005 funct3  in  3  IR[14:12].
REQ-006 funct7b5  in  1  IR[30].
REQ-007 Zero, lt, ltu  in  1 each  ALU flags: result==0, signed A<B, unsigned A<B.
REQ-008 MemReady  in  1  memory access completes this cycle.
REQ-009 ALUControl  out  4  encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 1000 SLL, 1001 SRL, 1010 SRA.
REQ-010 ALUSrcA  out  2  operand A select: 00 PC, 01 OldPC, 10 rs1, 11 zero.
REQ-011 ALUSrcB  out  2  operand B select: 00 rs2, 01 imm, 10 constant 4.
REQ-012 ResultSrc  out  2  result select: 00 ALUOut, 01 memory data, 10 ALUResult.
REQ-013 ImmSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U; decoded combinationally from op.
REQ-014 PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  out  1 each  write enables; AdrSrc 0=PC, 1=ALUOut.
REQ-015 Illegal  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-016 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, JALR1, JALR2, LUI, AUIPC.
REQ-017 Enables not listed for a state SHALL be 0; ALUControl SHALL default to ADD.
REQ-018 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, and IRWrite=PCWrite=MemReady; stay in FETCH while MemReady=0, else go to DECODE.
REQ-019 DECODE: ALUSrcA=01, ALUSrcB=01 (ALUOut<=OldPC+imm); next state by op.
  * 0000011 -> MEMADR; 0100011 -> MEMADR.
  * 0110011 -> EXECUTER; 0010011 -> EXECUTEI.
  * 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR1.
  * 0110111 -> LUI; 0010111 -> AUIPC.
  * Any other op -> FETCH, with Illegal=1 for that cycle.
REQ-020 MEMADR: ALUSrcA=10, ALUSrcB=01; go to MEMREAD for a load, MEMWRITE for a store.
REQ-021 MEMREAD: AdrSrc=1; hold while MemReady=0, then go to MEMWB.
REQ-022 MEMWB: ResultSrc=01, RegWrite=1; go to FETCH.
REQ-023 MEMWRITE: AdrSrc=1, MemWrite=1 held until MemReady=1; then go to FETCH.
REQ-024 EXECUTER / EXECUTEI: ALUSrcA=10, ALUSrcB=00 for EXECUTER and 01 for EXECUTEI; then go to ALUWB.
REQ-025 ALUWB: ResultSrc=00, RegWrite=1; go to FETCH.
REQ-026 ALU decode for R-type:
  * funct3 000: SUB if funct7b5=1, else ADD.
  * 001 SLL; 010 SLT; 011 SLTU; 100 XOR.
  * 101: SRA if funct7b5=1, else SRL.
  * 110 OR; 111 AND.
REQ-027 ALU decode for I-type SHALL match R-type, except funct3=000 SHALL always select ADD.
REQ-028 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUControl=SUB, ResultSrc=00; go to FETCH.
REQ-029 BRANCH PCWrite SHALL be the taken flag by funct3: 000 Zero, 001 ~Zero, 100 lt, 101 ~lt, 110 ltu, 111 ~ltu; other funct3 values SHALL give 0.
REQ-030 JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1; go to ALUWB.
REQ-031 JALR1: ALUSrcA=10, ALUSrcB=01; go to JALR2.
REQ-032 JALR2: same controls as JAL; go to ALUWB. The datapath clears the LSB.
REQ-033 LUI: ALUSrcA=11, ALUSrcB=01. AUIPC: ALUSrcA=01, ALUSrcB=01. Both go to ALUWB.
REQ-034 All outputs SHALL be combinational from the current state and the inputs; state advances on the rising edge of clk only.

Reset
REQ-035 While reset=1, state SHALL be FETCH and PCWrite, IRWrite, RegWrite, MemWrite and Illegal SHALL be 0, regardless of MemReady.
REQ-036 Reset asserted in any state, including a stalled MEMWRITE, SHALL abort the operation immediately.
REQ-037 After reset deasserts, the first FETCH SHALL start on the next rising edge.

Structure
REQ-038 A shared package SHALL hold the state enum, the ALUControl constants, the opcode constants and the ImmSrc/ALUSrc/ResultSrc encodings.
REQ-039 The ALU decode SHALL be a sub-module, alu_decoder.

Verification
REQ-040 The bench SHALL cover these directed scenarios:
  * add x3,x1,x2 (op 0110011, f3 000, f7b5 0), MemReady=1: FETCH, DECODE, EXECUTER, ALUWB; ALUControl=0000 in EXECUTER; RegWrite=1 only in ALUWB; 4 cycles.
  * sra (f3 101, f7b5 1) then srai: ALUControl=1010 in both. addi with f7b5=1: ALUControl=0000.
  * bne with Zero=0: PCWrite=1 in BRANCH. Same instruction with Zero=1: PCWrite=0. bgeu with ltu=1: PCWrite=0.
  * lw with MemReady low for 3 cycles in MEMREAD: state held, no RegWrite; MEMWB follows MemReady=1.
  * Opcode 1111111: Illegal=1 for one cycle in DECODE; next state is FETCH; no write enables asserted.
  * reset=1 mid-MEMWRITE: MemWrite drops to 0 asynchronously; after release, FETCH with IRWrite gated by MemReady.
